alu_pkt_parser: RTL and testbench

- Upstream framing stage between the UART receive AXI-stream byte output and the ALU controller.
- Parses each request packet: opcode, reserved byte, 16-bit little-endian length, then payload.
- Presents a one-shot header and the payload as little-endian words with byte-enable count and last flag.
- Rejects unknown opcodes and bad lengths, and aborts stalled packets on an inter-byte timeout.

---
 rtl/alu_pkt_parser_if.sv | 37 +++
 rtl/alu_pkt_parser.sv | 193 +++++++++++++++++++
 tb/tb_alu_pkt_parser.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkt_parser_if.sv
// Byte-stream input and header/word outputs of the ALU request packet parser.
interface alu_pkt_parser_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_BYTES = 4
);
    localparam int unsigned WORD_W = WORD_BYTES * DATA_WIDTH;
    localparam int unsigned NB_W   = $clog2(WORD_BYTES + 1);

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;

    logic                  hdr_valid_o;
    logic                  hdr_ready_i;
    logic [7:0]            hdr_opcode_o;
    logic [15:0]           hdr_len_o;

    logic                  word_valid_o;
    logic                  word_ready_i;
    logic [WORD_W-1:0]     word_data_o;
    logic [NB_W-1:0]       word_nbytes_o;
    logic                  word_last_o;

    // Parser side: consumes the byte stream, produces header and words.
    modport master (
        input  s_axis_tdata, s_axis_tvalid, hdr_ready_i, word_ready_i,
        output s_axis_tready, hdr_valid_o, hdr_opcode_o, hdr_len_o,
        output word_valid_o, word_data_o, word_nbytes_o, word_last_o
    );

    // Environment side: drives bytes and downstream readies.
    modport slave (
        output s_axis_tdata, s_axis_tvalid, hdr_ready_i, word_ready_i,
        input  s_axis_tready, hdr_valid_o, hdr_opcode_o, hdr_len_o,
        input  word_valid_o, word_data_o, word_nbytes_o, word_last_o
    );
endinterface

// File: rtl/alu_pkt_parser.sv
// Frames UART request bytes into a one-shot header plus little-endian payload words.
module alu_pkt_parser #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    alu_pkt_parser_if.master bus,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [15:0]      pkt_count_o
);
    localparam int unsigned WORD_W   = WORD_BYTES * DATA_WIDTH;
    localparam int unsigned NB_W     = $clog2(WORD_BYTES + 1);
    localparam int unsigned IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned LAST_IDX = WORD_BYTES - 1;
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [2:0] {IDLE, RSVD, LEN_LO, LEN_HI, HDR, PAYLOAD} state_e;

    state_e             state_q, state_d;
    logic [7:0]         op_q, len_lo_q, hdr_op_q;
    logic [15:0]        hdr_len_q, rem_q, cnt_q;
    logic               hdr_valid_q, word_valid_q, last_q, err_q;
    logic [1:0]         err_code_q, err_code_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  word_q;
    logic [NB_W-1:0]    nbytes_q;
    logic [TMO_W-1:0]   tmo_q;

    logic        byte_acc, hdr_hs, word_hs, tmo_state, tmo_run, tmo_fire;
    logic        err_set, pkt_done, len_ok;
    logic [7:0]  byte_in;
    logic [15:0] len_in;

    assign byte_in   = 8'(bus.s_axis_tdata);
    assign len_in    = {byte_in, len_lo_q};
    assign len_ok    = (len_in >= 16'd4);
    assign tmo_state = state_q inside {RSVD, LEN_LO, LEN_HI, PAYLOAD};
    assign tmo_run   = tmo_state && !bus.s_axis_tvalid && !word_valid_q;
    assign hdr_hs    = hdr_valid_q && bus.hdr_ready_i;
    assign word_hs   = word_valid_q && bus.word_ready_i;
    assign byte_acc  = bus.s_axis_tvalid && bus.s_axis_tready;

    // Byte acceptance: header bytes always, payload only while the word register can take one.
    assign bus.s_axis_tready = (state_q inside {IDLE, RSVD, LEN_LO, LEN_HI}) ||
                               ((state_q == PAYLOAD) && (rem_q != 16'd0) &&
                                (!word_valid_q || bus.word_ready_i));

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state, error strobes and packet completion.
    always_comb begin
        state_d    = state_q;
        err_set    = 1'b0;
        err_code_d = err_code_q;
        pkt_done   = 1'b0;
        tmo_fire   = 1'b0;
        case (state_q)
            IDLE: if (byte_acc) begin
                if (byte_in inside {8'hEC, 8'h01, 8'h02, 8'h03}) begin
                    state_d = RSVD;
                end else begin
                    err_set    = 1'b1;
                    err_code_d = 2'd1;
                end
            end
            RSVD:   if (byte_acc) state_d = LEN_LO;
            LEN_LO: if (byte_acc) state_d = LEN_HI;
            LEN_HI: if (byte_acc) begin
                if (len_ok) begin
                    state_d = HDR;
                end else begin
                    err_set    = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = IDLE;
                end
            end
            HDR: if (hdr_hs) begin
                if (hdr_len_q == 16'd4) begin
                    pkt_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (word_hs && last_q) begin
                pkt_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((TIMEOUT_CYCLES != 0) && tmo_run && (tmo_q == TMO_W'(TMO_LAST))) begin
            tmo_fire   = 1'b1;
            err_set    = 1'b1;
            err_code_d = 2'd3;
            state_d    = IDLE;
        end
    end

    // Error pulse, held error code and delivered-packet counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            cnt_q      <= 16'd0;
        end else begin
            err_q <= err_set;
            if (err_set)  err_code_q <= err_code_d;
            if (pkt_done) cnt_q      <= cnt_q + 16'd1;
        end
    end

    // Header capture; outputs only change when a new good header is latched.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q        <= 8'd0;
            len_lo_q    <= 8'd0;
            hdr_op_q    <= 8'd0;
            hdr_len_q   <= 16'd0;
            hdr_valid_q <= 1'b0;
        end else begin
            if (state_q == IDLE && byte_acc)   op_q     <= byte_in;
            if (state_q == LEN_LO && byte_acc) len_lo_q <= byte_in;
            if (state_q == LEN_HI && byte_acc && len_ok) begin
                hdr_op_q    <= op_q;
                hdr_len_q   <= len_in;
                hdr_valid_q <= 1'b1;
            end else if (hdr_hs) begin
                hdr_valid_q <= 1'b0;
            end
        end
    end

    // Inter-byte idle counter; paused while a finished word waits downstream.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                            tmo_q <= '0;
        else if (byte_acc || !tmo_state || tmo_fire) tmo_q <= '0;
        else if (tmo_run)                       tmo_q <= tmo_q + TMO_W'(1);
    end

    // Payload packing into the word register and word handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rem_q        <= 16'd0;
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            nbytes_q     <= '0;
            last_q       <= 1'b0;
        end else begin
            if (hdr_hs) begin
                rem_q <= hdr_len_q - 16'd4;
                idx_q <= '0;
            end
            if (tmo_fire) begin
                rem_q <= 16'd0;
                idx_q <= '0;
            end
            if (word_hs) word_valid_q <= 1'b0;
            if (state_q == PAYLOAD && byte_acc) begin
                rem_q <= rem_q - 16'd1;
                if (idx_q == '0) word_q <= WORD_W'(bus.s_axis_tdata);
                else             word_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= bus.s_axis_tdata;
                if (idx_q == IDX_W'(LAST_IDX) || rem_q == 16'd1) begin
                    word_valid_q <= 1'b1;
                    nbytes_q     <= NB_W'(idx_q) + NB_W'(1);
                    last_q       <= (rem_q == 16'd1);
                    idx_q        <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign bus.hdr_valid_o   = hdr_valid_q;
    assign bus.hdr_opcode_o  = hdr_op_q;
    assign bus.hdr_len_o     = hdr_len_q;
    assign bus.word_valid_o  = word_valid_q;
    assign bus.word_data_o   = word_q;
    assign bus.word_nbytes_o = nbytes_q;
    assign bus.word_last_o   = last_q;
    assign err_o             = err_q;
    assign err_code_o        = err_code_q;
    assign pkt_count_o       = cnt_q;
endmodule

// File: tb/tb_alu_pkt_parser.sv
// Self-checking bench for alu_pkt_parser: directed and randomized packet streams vs. a packet-level model.
module tb_alu_pkt_parser;
    localparam int unsigned DW  = 8;
    localparam int unsigned WB  = 4;
    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] pkt_cnt;

    alu_pkt_parser_if #(.DATA_WIDTH(DW), .WORD_BYTES(WB)) bus ();

    alu_pkt_parser #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus),
        .err_o(err), .err_code_o(err_code), .pkt_count_o(pkt_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int rdy_mode = 0;
    int stall_seen = 0;
    int stall_viol = 0;
    logic [47:0] obs_q[$];
    logic [47:0] exp_q[$];

    // Event capture at mid-cycle: values here are what the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.hdr_valid_o && bus.hdr_ready_i)
                obs_q.push_back({2'd0, 22'd0, bus.hdr_opcode_o, bus.hdr_len_o});
            if (bus.word_valid_o && bus.word_ready_i)
                obs_q.push_back({2'd1, 10'd0, bus.word_last_o, bus.word_nbytes_o, bus.word_data_o});
            if (err)
                obs_q.push_back({2'd2, 44'd0, err_code});
            if (bus.word_valid_o && !bus.word_ready_i) begin
                stall_seen++;
                if (bus.s_axis_tready) stall_viol++;
            end
        end
    end

    // Downstream readiness: 0 always ready, 1 random, 2 words blocked.
    initial begin
        bus.hdr_ready_i  = 1'b1;
        bus.word_ready_i = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                1: begin
                    bus.hdr_ready_i  = 1'($urandom_range(0, 1));
                    bus.word_ready_i = 1'($urandom_range(0, 1));
                end
                2: begin
                    bus.hdr_ready_i  = 1'b1;
                    bus.word_ready_i = 1'b0;
                end
                default: begin
                    bus.hdr_ready_i  = 1'b1;
                    bus.word_ready_i = 1'b1;
                end
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.s_axis_tdata  = b;
        bus.s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.s_axis_tready) break;
            n++;
            if (n > 2000) begin
                checks++; errors++;
                $display("FAIL send_byte: byte %h not accepted within %0d cycles", b, n);
                break;
            end
        end
        @(posedge clk); #2;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'($urandom);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap_max);
        foreach (s[i]) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            send_byte(s[i]);
        end
    endtask

    // Packet-level reference: walks a complete byte stream and lists the expected events.
    task automatic model_stream(input logic [7:0] s_in[$]);
        logic [7:0]  s[$];
        logic [7:0]  op, b;
        logic [15:0] len;
        logic [31:0] w;
        int n, k;
        s = s_in;
        while (s.size() > 0) begin
            op = s.pop_front();
            if (!(op == 8'hEC || op == 8'h01 || op == 8'h02 || op == 8'h03)) begin
                exp_q.push_back({2'd2, 44'd0, 2'd1});
                continue;
            end
            b = s.pop_front();
            len[7:0]  = s.pop_front();
            len[15:8] = s.pop_front();
            if (len < 16'd4) begin
                exp_q.push_back({2'd2, 44'd0, 2'd2});
                continue;
            end
            exp_q.push_back({2'd0, 22'd0, op, len});
            n = int'(len) - 4;
            while (n > 0) begin
                k = (n > int'(WB)) ? int'(WB) : n;
                w = 32'd0;
                for (int j = 0; j < k; j++) w[8*j +: 8] = s.pop_front();
                n -= k;
                exp_q.push_back({2'd1, 10'd0, (n == 0), 3'(k), w});
            end
            exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        end
    endtask

    task automatic clear_events();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'd0;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++; if (bus.hdr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %b expected 0", bus.hdr_valid_o); end
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", bus.word_valid_o); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_cnt); end
        checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", bus.s_axis_tready); end
    endtask

    task automatic test_add();
        logic [7:0] s[$];
        clear_events();
        s = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        model_stream(s);
        send_stream(s, 0);
        idle(10);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL add_event[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
        checks++; if (pkt_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL add_pkt_count: got %0d expected %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_echo();
        logic [7:0] s[$];
        clear_events();
        s = '{8'hEC, 8'h00, 8'h0A, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
              8'hEC, 8'h00, 8'h04, 8'h00,
              8'hEC, 8'h55, 8'h04, 8'h01};
        for (int i = 0; i < 256; i++) s.push_back(8'($urandom));
        model_stream(s);
        send_stream(s, 0);
        idle(10);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL echo_event[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
        checks++; if (pkt_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL echo_pkt_count: got %0d expected %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_bad();
        logic [7:0] s[$];
        clear_events();
        s = '{8'h7F};
        model_stream(s);
        send_stream(s, 0);
        idle(2);
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL bad_opcode_code: got %0d expected 1", err_code); end
        s = '{8'h02, 8'h00, 8'h03, 8'h00,
              8'h02, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        model_stream(s);
        send_stream(s, 2);
        idle(10);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bad_event[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL bad_len_code_held: got %0d expected 2", err_code); end
        checks++; if (pkt_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bad_pkt_count: got %0d expected %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] s[$];
        clear_events();
        stall_seen = 0;
        stall_viol = 0;
        s = '{8'h02, 8'h00, 8'd20, 8'h00};
        for (int i = 0; i < 16; i++) s.push_back(8'($urandom));
        model_stream(s);
        rdy_mode = 2;
        fork
            send_stream(s, 0);
            begin repeat (50) @(posedge clk); rdy_mode = 0; end
        join
        idle(10);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_event[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_tready_while_full: got %0d cycles expected 0", stall_viol); end
        checks++; if (stall_seen < 40) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected >=40", stall_seen); end
        checks++; if (pkt_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_pkt_count: got %0d expected %0d", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        clear_events();
        s = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
        send_stream(s, 0);
        idle(int'(TMO) - 1);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL tmo_early: got %0d events expected 1", obs_q.size()); end
        idle(5);
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL tmo_event_count: got %0d expected 2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            checks++;
            if (obs_q[0] !== {2'd0, 22'd0, 8'h01, 16'h000C}) begin errors++; $display("FAIL tmo_header: got %h expected %h", obs_q[0], {2'd0, 22'd0, 8'h01, 16'h000C}); end
            checks++;
            if (obs_q[1] !== {2'd2, 44'd0, 2'd3}) begin errors++; $display("FAIL tmo_err_event: got %h expected %h", obs_q[1], {2'd2, 44'd0, 2'd3}); end
        end
        checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL tmo_err_code: got %0d expected 3", err_code); end
        checks++; if (pkt_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL tmo_pkt_count: got %0d expected %0d", pkt_cnt, exp_cnt); end
        clear_events();
        s = '{8'h03, 8'h00, 8'h0B, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
        model_stream(s);
        send_stream(s, 3);
        idle(10);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL tmo_next_event[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
    endtask

    task automatic test_random(input string name, input int npkts, input int gap_max, input int mode);
        logic [7:0] s[$];
        logic [7:0] ops[4] = '{8'hEC, 8'h01, 8'h02, 8'h03};
        logic [7:0] op;
        int unsigned r, len;
        clear_events();
        for (int p = 0; p < npkts; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do op = 8'($urandom); while (op inside {8'hEC, 8'h01, 8'h02, 8'h03});
                s.push_back(op);
            end else begin
                len = (r == 1) ? $urandom_range(0, 3) : $urandom_range(4, 24);
                s.push_back(ops[$urandom_range(0, 3)]);
                s.push_back(8'($urandom));
                s.push_back(8'(len));
                s.push_back(8'(len >> 8));
                if (len >= 4) for (int i = 0; i < int'(len) - 4; i++) s.push_back(8'($urandom));
            end
        end
        model_stream(s);
        rdy_mode = mode;
        send_stream(s, gap_max);
        rdy_mode = 0;
        idle(30);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_event[%0d]: got %h expected %h", name, i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
        checks++; if (pkt_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL %s_pkt_count: got %0d expected %0d", name, pkt_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        clear_events();
        rdy_mode = 2;
        s = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(s, 0);
        idle(2);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.hdr_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_hdr_valid: got %b expected 0", bus.hdr_valid_o); end
        checks++; if (bus.word_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_word_valid: got %b expected 0", bus.word_valid_o); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_pkt_count: got %0d expected 0", pkt_cnt); end
        exp_cnt = 0;
        rdy_mode = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        idle(1);
        clear_events();
        s = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        model_stream(s);
        send_stream(s, 1);
        idle(10);
        for (int i = 0; i < ((exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size()); i++) begin
            checks++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_event[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 48'hx, (i < exp_q.size()) ? exp_q[i] : 48'hx);
            end
        end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_pkt_after: got %0d expected 1", pkt_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_add();
        test_echo();
        test_bad();
        test_backpressure();
        test_timeout();
        test_random("back_to_back", 20, 0, 0);
        test_random("random", 30, 6, 1);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
